// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: operation codes and FSM states.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_MUL = 3'b101
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } alu_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier: one partial product per cycle, WIDTH cycles per start.
// done is high during the cycle whose edge retires the last step; product is valid then.
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] mcand_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [2*WIDTH-1:0] acc_next_s;
    logic [WIDTH-1:0]   mplier_r;
    logic [CW-1:0]      cnt_r;
    logic               busy_r;

    // Accumulate the current partial product when the low multiplier bit is set.
    always_comb begin
        acc_next_s = acc_r;
        if (mplier_r[0]) begin
            acc_next_s = acc_r + mcand_r;
        end else begin
            acc_next_s = acc_r;
        end
    end

    assign done    = busy_r && (cnt_r == CW'(1));
    assign product = acc_next_s;

    // Shift-add iteration registers, loaded on start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_r  <= {(2*WIDTH){1'b0}};
            acc_r    <= {(2*WIDTH){1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            cnt_r    <= {CW{1'b0}};
            busy_r   <= 1'b0;
        end else if (start) begin
            mcand_r  <= {{WIDTH{1'b0}}, a};
            acc_r    <= {(2*WIDTH){1'b0}};
            mplier_r <= b;
            cnt_r    <= CW'(WIDTH);
            busy_r   <= 1'b1;
        end else if (busy_r) begin
            acc_r    <= acc_next_s;
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            cnt_r    <= cnt_r - CW'(1);
            busy_r   <= (cnt_r != CW'(1));
        end else begin
            busy_r   <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshake; single-cycle ops go straight to DONE.
// Define ALU_SEQ_MUL_EN to build the shift-add multiplier; otherwise op 101 is illegal.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             overflow,
    output logic             carry,
    output logic             zero,
    output logic             illegal
);

    alu_state_e         state_r;
    alu_state_e         state_next_s;
    logic               accept_s;
    logic               is_mul_s;
    logic               mul_done_s;
    logic [2*WIDTH-1:0] mul_product_s;
    logic [WIDTH:0]     sum_s;
    logic [WIDTH:0]     diff_s;
    logic [WIDTH-1:0]   alu_res_s;
    logic               alu_ovf_s;
    logic               alu_carry_s;
    logic               alu_ill_s;
    logic [WIDTH-1:0]   res_r;
    logic               ovf_r;
    logic               carry_r;
    logic               zero_r;
    logic               ill_r;

    assign accept_s  = in_valid && (state_r == IDLE);
    assign in_ready  = (state_r == IDLE);
    assign out_valid = (state_r == DONE);
    assign res       = res_r;
    assign overflow  = ovf_r;
    assign carry     = carry_r;
    assign zero      = zero_r;
    assign illegal   = ill_r;

`ifdef ALU_SEQ_MUL_EN
    assign is_mul_s = (op == ALU_MUL);

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (accept_s && is_mul_s),
        .a       (a),
        .b       (b),
        .done    (mul_done_s),
        .product (mul_product_s)
    );
`else
    assign is_mul_s      = 1'b0;
    assign mul_done_s    = 1'b0;
    assign mul_product_s = {(2*WIDTH){1'b0}};
`endif

    // Single-cycle result from the live operands, captured on acceptance.
    always_comb begin
        sum_s       = {1'b0, a} + {1'b0, b};
        diff_s      = {1'b0, a} - {1'b0, b};
        alu_res_s   = {WIDTH{1'b0}};
        alu_ovf_s   = 1'b0;
        alu_carry_s = 1'b0;
        alu_ill_s   = 1'b0;
        case (op)
            ALU_ADD: begin
                alu_res_s   = sum_s[WIDTH-1:0];
                alu_carry_s = sum_s[WIDTH];
                alu_ovf_s   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                alu_res_s   = diff_s[WIDTH-1:0];
                alu_carry_s = diff_s[WIDTH];
                alu_ovf_s   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_AND: alu_res_s = a & b;
            ALU_OR:  alu_res_s = a | b;
            ALU_XOR: alu_res_s = a ^ b;
            default: alu_ill_s = 1'b1;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = is_mul_s ? BUSY : DONE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            BUSY: begin
                if (mul_done_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = BUSY;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Result and flag registers; held untouched while DONE waits for the consumer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_r   <= {WIDTH{1'b0}};
            ovf_r   <= 1'b0;
            carry_r <= 1'b0;
            zero_r  <= 1'b0;
            ill_r   <= 1'b0;
        end else if (accept_s && !is_mul_s) begin
            res_r   <= alu_res_s;
            ovf_r   <= alu_ovf_s;
            carry_r <= alu_carry_s;
            zero_r  <= (alu_res_s == {WIDTH{1'b0}});
            ill_r   <= alu_ill_s;
        end else if ((state_r == BUSY) && mul_done_s) begin
            res_r   <= mul_product_s[WIDTH-1:0];
            ovf_r   <= |mul_product_s[2*WIDTH-1:WIDTH];
            carry_r <= 1'b0;
            zero_r  <= (mul_product_s[WIDTH-1:0] == {WIDTH{1'b0}});
            ill_r   <= 1'b0;
        end else begin
            res_r   <= res_r;
        end
    end

endmodule
